// File: rtl/error_display_sequencer.sv
// error_display_sequencer
// Shares one error-message 7-segment decoder round-robin between four latched
// error sources and scans the decoder output across four digit anodes.
// Optional feature: define BLINK_EN to blank the anodes in alternate quarters
// of each message's hold time (steady display when undefined).
module error_display_sequencer #(
  parameter int CLK_DIV    = 50000,
  parameter int HOLD_TICKS = 512,
  parameter int N_ERR      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_ERR-1:0] err_req,
  input  logic             err_clr,
  output logic [1:0]       char_sel,
  output logic [1:0]       err_idx,
  output logic [3:0]       digit_en,
  output logic             active
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HOLD_TICKS);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, NEXT} state_t;

  state_t           state, state_next;
  logic [N_ERR-1:0] pending, pending_next;
  logic [PW-1:0]    prescaler;
  logic [HW-1:0]    hold, hold_next;
  logic [1:0]       digit, digit_next;
  logic [1:0]       last, last_next;
  logic [1:0]       idx_next;
  logic [2:0]       pick;
  logic             tick;
  logic             blank;
  logic [1:0]       char_sel_next;
  logic [3:0]       digit_en_next;
  logic             active_next;

  // First set request found scanning from the slot after 'from', wrapping;
  // result is {found, index}. Scanning all four slots lets a lone source win again.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = from + 2'(k);
      if (!res[2] && req[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign tick = (prescaler == PRE_LAST);

`ifdef BLINK_EN
  localparam int BLINK_BIT = HW - 2;
  assign blank = hold_next[BLINK_BIT];
`else
  assign blank = 1'b0;
`endif

  // Free-running scan prescaler producing one tick every CLK_DIV clocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prescaler <= '0;
    else       prescaler <= tick ? '0 : prescaler + PW'(1);
  end

  // Next-state logic: latch requests, pick the next source, step digit and hold.
  always_comb begin
    state_next   = state;
    pending_next = (err_clr ? '0 : pending) | err_req;
    hold_next    = hold;
    digit_next   = digit;
    last_next    = last;
    idx_next     = err_idx;
    pick         = 3'b000;
    unique case (state)
      IDLE: begin
        pick = rr_pick(pending_next, last);
        if (tick && pick[2]) begin
          idx_next   = pick[1:0];
          last_next  = pick[1:0];
          hold_next  = '0;
          digit_next = 2'd0;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (pending_next == '0) begin
          state_next = IDLE;
        end else if (tick) begin
          digit_next = digit + 2'd1;
          hold_next  = hold + HW'(1);
          if (hold == HOLD_LAST) state_next = NEXT;
        end
      end
      NEXT: begin
        // A source whose level is still high keeps its pending bit and is re-shown later.
        pending_next = ((err_clr ? '0 : pending) & ~(N_ERR'(1) << err_idx)) | err_req;
        pick = rr_pick(pending_next, last);
        if (pick[2]) begin
          idx_next   = pick[1:0];
          last_next  = pick[1:0];
          hold_next  = '0;
          digit_next = 2'd0;
          state_next = SHOW;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values computed from the next state so the pins come straight from flops.
  always_comb begin
    active_next   = (state_next != IDLE);
    char_sel_next = 2'd0;
    digit_en_next = 4'b1111;
    if (state_next == SHOW) begin
      char_sel_next = digit_next;
      digit_en_next = ~(4'b0001 << digit_next);
      if (blank) digit_en_next = 4'b1111;
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      hold     <= '0;
      digit    <= 2'd0;
      last     <= 2'd3;
      err_idx  <= 2'd0;
      char_sel <= 2'd0;
      digit_en <= 4'b1111;
      active   <= 1'b0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      hold     <= hold_next;
      digit    <= digit_next;
      last     <= last_next;
      err_idx  <= idx_next;
      char_sel <= char_sel_next;
      digit_en <= digit_en_next;
      active   <= active_next;
    end
  end

endmodule

// File: tb/tb_error_display_sequencer.sv
// tb_error_display_sequencer
// Table vectors, hand-written corner sequences and random traffic against a
// slot-level reference model of the error display sequencer.
module tb_error_display_sequencer;

  localparam int CLK_DIV    = 4;
  localparam int HOLD_TICKS = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] err_req = 4'b0;
  logic       err_clr = 1'b0;
  logic [1:0] char_sel;
  logic [1:0] err_idx;
  logic [3:0] digit_en;
  logic       active;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = dark, 1 = showing a message, 2 = hand-over clock.
  int         mMode;
  logic [3:0] mPend;
  int         mPre;
  int         mHold;
  int         mPos;
  int         mLast;
  int         mCur;

  typedef struct {
    logic [3:0] req;
    logic       clr;
    int         cycles;
    logic       act;
    logic [1:0] idx;
    logic [1:0] chr;
    logic [3:0] en;
  } vec_t;

  vec_t tbl[10];

  error_display_sequencer #(
    .CLK_DIV(CLK_DIV),
    .HOLD_TICKS(HOLD_TICKS),
    .N_ERR(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .err_req(err_req),
    .err_clr(err_clr),
    .char_sel(char_sel),
    .err_idx(err_idx),
    .digit_en(digit_en),
    .active(active)
  );

  // Free-running system clock.
  always #5 clock = ~clock;

  // Hard stop in case something never settles.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int rrNext(input logic [3:0] p, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (p[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mMode = 0; mPend = 4'b0; mPre = 0; mHold = 0; mPos = 0; mLast = 3; mCur = 0;
  endtask

  task automatic startMessage(input int i);
    mCur = i; mLast = i; mHold = 0; mPos = 0; mMode = 1;
  endtask

  task automatic modelStep(input logic [3:0] req, input logic clr);
    logic       tick;
    logic [3:0] np;
    int         nxt;
    tick = (mPre == CLK_DIV - 1);
    mPre = (mPre + 1) % CLK_DIV;
    np = clr ? 4'b0 : mPend;
    if (mMode == 2) np[mCur] = 1'b0;
    np = np | req;
    mPend = np;
    case (mMode)
      0: if (tick && np != 4'b0) startMessage(rrNext(np, mLast));
      1: begin
        if (np == 4'b0) mMode = 0;
        else if (tick) begin
          mHold = mHold + 1;
          mPos = (mPos + 1) % 4;
          if (mHold == HOLD_TICKS) mMode = 2;
        end
      end
      default: begin
        nxt = rrNext(np, mLast);
        if (nxt >= 0) startMessage(nxt);
        else mMode = 0;
      end
    endcase
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] expEn;
    int         expChar;
    expEn = 4'b1111;
    expChar = 0;
    if (mMode == 1) begin
      expChar = mPos;
      expEn[mPos] = 1'b0;
`ifdef BLINK_EN
      if ((mHold / (HOLD_TICKS / 4)) % 2 == 1) expEn = 4'b1111;
`endif
    end
    checkVal("active", int'(active), (mMode != 0) ? 1 : 0);
    checkVal("err_idx", int'(err_idx), mCur);
    checkVal("char_sel", int'(char_sel), expChar);
    checkVal("digit_en", int'(digit_en), int'(expEn));
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic clr);
    err_req = req;
    err_clr = clr;
    @(posedge clock);
    modelStep(req, clr);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    checkVal("rst.active", int'(active), 0);
    checkVal("rst.digit_en", int'(digit_en), 15);
    checkVal("rst.char_sel", int'(char_sel), 0);
    checkVal("rst.err_idx", int'(err_idx), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    err_req = 4'b0;
    err_clr = 1'b0;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic waitActive(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      applyStimulus(4'b0, 1'b0);
      if (active) break;
    end
    checkVal(name, int'(active), 1);
  endtask

  initial begin
    int         got[3];
    int         n;
    logic [3:0] prevEn;
    logic [3:0] rq;
    logic       cl;

    tbl[0] = '{4'b0010, 1'b0, 1,  1'b0, 2'd0, 2'd0, 4'b1111};
    tbl[1] = '{4'b0000, 1'b0, 2,  1'b0, 2'd0, 2'd0, 4'b1111};
    tbl[2] = '{4'b0000, 1'b0, 1,  1'b1, 2'd1, 2'd0, 4'b1110};
    tbl[3] = '{4'b0000, 1'b0, 3,  1'b1, 2'd1, 2'd0, 4'b1110};
    tbl[4] = '{4'b0000, 1'b0, 1,  1'b1, 2'd1, 2'd1, 4'b1101};
    tbl[5] = '{4'b0000, 1'b0, 4,  1'b1, 2'd1, 2'd2, 4'b1011};
    tbl[6] = '{4'b0000, 1'b0, 4,  1'b1, 2'd1, 2'd3, 4'b0111};
    tbl[7] = '{4'b0000, 1'b0, 4,  1'b1, 2'd1, 2'd0, 4'b1110};
    tbl[8] = '{4'b0000, 1'b0, 16, 1'b1, 2'd1, 2'd0, 4'b1111};
    tbl[9] = '{4'b0000, 1'b0, 1,  1'b0, 2'd1, 2'd0, 4'b1111};
`ifdef BLINK_EN
    tbl[5].en = 4'b1111;
    tbl[6].en = 4'b1111;
`endif

    // Single request: one full message, then dark again.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].req, tbl[i].clr);
      for (int c = 1; c < tbl[i].cycles; c++) applyStimulus(4'b0, 1'b0);
      checkVal($sformatf("tbl%0d.active", i), int'(active), int'(tbl[i].act));
      checkVal($sformatf("tbl%0d.err_idx", i), int'(err_idx), int'(tbl[i].idx));
      checkVal($sformatf("tbl%0d.char_sel", i), int'(char_sel), int'(tbl[i].chr));
      checkVal($sformatf("tbl%0d.digit_en", i), int'(digit_en), int'(tbl[i].en));
    end

    // Three sources latched together are shown in round-robin order 0, 1, 3.
    doReset();
    got = '{-1, -1, -1};
    n = 0;
    prevEn = digit_en;
    applyStimulus(4'b1011, 1'b0);
    for (int c = 0; c < 150; c++) begin
      prevEn = digit_en;
      applyStimulus(4'b0, 1'b0);
      if (prevEn == 4'b1111 && digit_en != 4'b1111) begin
        if (n < 3) got[n] = int'(err_idx);
        n++;
      end
    end
    checkVal("order.count", n, 3);
    checkVal("order.first", got[0], 0);
    checkVal("order.second", got[1], 1);
    checkVal("order.third", got[2], 3);
    checkVal("order.idle", int'(active), 0);

    // Clear together with a new request keeps the new one pending.
    doReset();
    applyStimulus(4'b0001, 1'b0);
    waitActive("clrReq.show", 20);
    repeat (5) applyStimulus(4'b0, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkVal("clrReq.active", int'(active), 1);
    checkVal("clrReq.idx0", int'(err_idx), 0);
    for (int c = 0; c < 60; c++) begin
      applyStimulus(4'b0, 1'b0);
      if (active && err_idx == 2'd2) break;
    end
    checkVal("clrReq.idx2", int'(err_idx), 2);
    checkVal("clrReq.active2", int'(active), 1);

    // Clear alone aborts the message on the next clock.
    doReset();
    applyStimulus(4'b0001, 1'b0);
    waitActive("clr.show", 20);
    repeat (3) applyStimulus(4'b0, 1'b0);
    applyStimulus(4'b0, 1'b1);
    checkVal("clr.digit_en", int'(digit_en), 15);
    checkVal("clr.active", int'(active), 0);
    checkVal("clr.char_sel", int'(char_sel), 0);
    repeat (20) applyStimulus(4'b0, 1'b0);
    checkVal("clr.stays", int'(active), 0);

    // Asynchronous reset in the middle of a message.
    doReset();
    applyStimulus(4'b0100, 1'b0);
    waitActive("rstMid.show", 20);
    repeat (6) applyStimulus(4'b0, 1'b0);
    doReset();
    repeat (20) applyStimulus(4'b0, 1'b0);
    checkVal("rstMid.stays", int'(active), 0);

    // Random traffic: sparse pulses, held levels and occasional clears.
    doReset();
    rq = 4'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) rq = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) rq = 4'b0;
      cl = ($urandom_range(0, 119) == 0);
      applyStimulus(rq, cl);
    end
    repeat (100) applyStimulus(4'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
